// File: rtl/mem_write_buffer.sv
// mem_write_buffer
// Store buffer that sits between the core's memory-access signals and a word-addressed
// data RAM. The RAM has an asynchronous read, a posedge write and no byte enables.
//
// Word and byte stores are queued. They later drain into the RAM one per cycle, oldest
// first. Each drain is a single-cycle read-merge-write: the RAM's async read data fills
// the lanes that the entry does not cover.
//
// Loads (word or zero-extended byte) are served combinationally whenever the RAM port is
// not needed by a drain. A load that hits a buffered word stalls the core. The buffer
// then drains until no entry matches, so the load always sees up-to-date RAM contents.
//
// Ports:
//   clk        system clock, all state on rising edge
//   reset      synchronous active-high reset, clears buffer state
//   core_we    store request
//   core_re    load request (wins over a simultaneous store)
//   core_byte  1 = byte access, 0 = word access
//   core_addr  byte address from the ALU
//   core_wd    store data
//   core_rd    load data to the result mux
//   stall      core must hold its state this cycle
//   mem_we     RAM write enable
//   mem_a      RAM byte address (RAM decodes [9:2])
//   mem_wd     RAM write data
//   mem_rd     RAM async read data for mem_a
//   wb_count   number of occupied buffer entries
module mem_write_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             core_we,
  input  logic             core_re,
  input  logic             core_byte,
  input  logic [31:0]      core_addr,
  input  logic [31:0]      core_wd,
  output logic [31:0]      core_rd,
  output logic             stall,
  output logic             mem_we,
  output logic [31:0]      mem_a,
  output logic [31:0]      mem_wd,
  input  logic [31:0]      mem_rd,
  output logic [PTR_W:0]   wb_count
);

  // Entry storage
  logic [29:0]      addr_q [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [3:0]       mask_q [DEPTH];
  logic [DEPTH-1:0] valid_q;

  logic [PTR_W-1:0] head_q;
  logic [PTR_W-1:0] tail_q;
  logic [PTR_W:0]   count_q;

  // Request decode
  logic        store_req;
  logic        full;
  logic        hazard;
  logic        push;
  logic        drain_en;
  logic        pop;
  logic        load_en;

  // Formatted incoming store
  logic [31:0] new_data;
  logic [3:0]  new_mask;

  // Head entry merge with RAM contents
  logic [29:0] head_addr;
  logic [31:0] head_data;
  logic [3:0]  head_mask;
  logic [31:0] merged;

  // Load data path
  logic [31:0] rd_shifted;

  // A load masks any store presented in the same cycle.
  assign store_req = core_we && !core_re;
  assign full      = (count_q == (PTR_W + 1)'(DEPTH));

  // Compare whole word addresses only: a load that overlaps a buffered word in any byte
  // has to wait for that word to reach the RAM.
  always_comb begin
    hazard = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (addr_q[i] == core_addr[31:2])) begin
        hazard = 1'b1;
      end
    end
    hazard = hazard && core_re;
  end

  assign stall   = (store_req && full) || hazard;
  assign push    = store_req && !full;
  assign load_en = core_re && !hazard;

  // The RAM port is free only when the core is not using it, or the core is stalled
  // anyway. This also keeps push and pop from ever happening in the same cycle.
  assign drain_en = (count_q != '0) && ((!core_re && !core_we) || stall);
  assign pop      = drain_en && !reset;

  always_comb begin
    if (core_byte) begin
      new_mask = 4'b0001 << core_addr[1:0];
      new_data = {4{core_wd[7:0]}};
    end else begin
      new_mask = 4'b1111;
      new_data = core_wd;
    end
  end

  assign head_addr = addr_q[head_q];
  assign head_data = data_q[head_q];
  assign head_mask = mask_q[head_q];

  always_comb begin
    for (int unsigned l = 0; l < 4; l++) begin
      merged[8*l +: 8] = head_mask[l] ? head_data[8*l +: 8] : mem_rd[8*l +: 8];
    end
  end

  assign rd_shifted = mem_rd >> {core_addr[1:0], 3'b000};

  // RAM port and load data mux
  always_comb begin
    mem_a   = core_addr;
    mem_we  = 1'b0;
    mem_wd  = 32'h0;
    core_rd = 32'h0;
    if (drain_en) begin
      mem_a  = {head_addr, 2'b00};
      mem_we = !reset;
      mem_wd = merged;
    end else if (load_en) begin
      core_rd = core_byte ? {24'h0, rd_shifted[7:0]} : mem_rd;
    end
  end

  assign wb_count = count_q;

  // Pointers, occupancy and valid flags
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      if (push) begin
        valid_q[tail_q] <= 1'b1;
        tail_q          <= tail_q + 1'b1;
      end
      if (pop) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + 1'b1;
      end
      if (push && !pop) begin
        count_q <= count_q + 1'b1;
      end else if (pop && !push) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  // Entry payload needs no reset: it is qualified by valid_q.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      addr_q[tail_q] <= core_addr[31:2];
      data_q[tail_q] <= new_data;
      mask_q[tail_q] <= new_mask;
    end
  end

endmodule

// File: tb/tb_mem_write_buffer.sv
module tb_mem_write_buffer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned PTR_W = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic             core_we;
  logic             core_re;
  logic             core_byte;
  logic [31:0]      core_addr;
  logic [31:0]      core_wd;
  logic [31:0]      core_rd;
  logic             stall;
  logic             mem_we;
  logic [31:0]      mem_a;
  logic [31:0]      mem_wd;
  logic [31:0]      mem_rd;
  logic [PTR_W:0]   wb_count;

  always #5 clk = ~clk;

  mem_write_buffer #(
    .DEPTH(DEPTH),
    .PTR_W(PTR_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .core_we  (core_we),
    .core_re  (core_re),
    .core_byte(core_byte),
    .core_addr(core_addr),
    .core_wd  (core_wd),
    .core_rd  (core_rd),
    .stall    (stall),
    .mem_we   (mem_we),
    .mem_a    (mem_a),
    .mem_wd   (mem_wd),
    .mem_rd   (mem_rd),
    .wb_count (wb_count)
  );

  // Data RAM: async read, posedge write
  logic [31:0] ram    [256];
  // Expected RAM contents, updated from the bench's own scoreboard
  logic [31:0] shadow [256];

  assign mem_rd = ram[mem_a[9:2]];

  always @(posedge clk) begin
    if (mem_we) ram[mem_a[9:2]] <= mem_wd;
  end

  typedef struct {
    logic [29:0] wa;
    logic [31:0] data;
    logic [3:0]  mask;
  } entry_t;

  entry_t sb[$];

  int total = 0;
  int bad   = 0;

  logic [31:0] rd_seen;
  logic        st_seen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input entry_t e);
    logic [31:0] r;
    for (int l = 0; l < 4; l++) r[8*l +: 8] = e.mask[l] ? e.data[8*l +: 8] : old[8*l +: 8];
    return r;
  endfunction

  // One clock cycle: drive, predict from the model, check at negedge, update the model.
  task automatic cyc(input logic we, input logic re, input logic byt,
                     input logic [31:0] addr, input logic [31:0] wd, input logic rst);
    logic   e_full, e_haz, e_stall, e_drain, e_push, e_load;
    entry_t ne, he;
    logic [31:0] exp_rd, w;
    core_we   = we;
    core_re   = re;
    core_byte = byt;
    core_addr = addr;
    core_wd   = wd;
    reset     = rst;
    e_full = (sb.size() == DEPTH);
    e_haz  = 1'b0;
    foreach (sb[i]) if (re && sb[i].wa == addr[31:2]) e_haz = 1'b1;
    e_stall = (we && !re && e_full) || e_haz;
    e_drain = (sb.size() != 0) && ((!re && !we) || e_stall) && !rst;
    e_push  = we && !re && !e_full;
    e_load  = re && !e_haz;
    @(negedge clk);
    rd_seen = core_rd;
    st_seen = stall;
    chk("stall", {31'h0, stall}, {31'h0, e_stall});
    chk("mem_we", {31'h0, mem_we}, {31'h0, e_drain});
    chk("wb_count", {29'h0, wb_count}, 32'(sb.size()));
    if (e_drain) begin
      he = sb[0];
      chk("drain_a", mem_a, {he.wa, 2'b00});
      chk("drain_wd", mem_wd, merge(shadow[he.wa[7:0]], he));
    end else if (!rst && e_load) begin
      w = shadow[addr[9:2]];
      exp_rd = byt ? {24'h0, w[8*addr[1:0] +: 8]} : w;
      chk("load_rd", core_rd, exp_rd);
      chk("load_a", mem_a, addr);
    end else if (!rst && !re) begin
      chk("idle_rd", core_rd, 32'h0);
      chk("idle_wd", mem_wd, 32'h0);
    end
    @(posedge clk);
    if (rst) begin
      sb.delete();
    end else begin
      if (e_drain) begin
        he = sb.pop_front();
        shadow[he.wa[7:0]] = merge(shadow[he.wa[7:0]], he);
      end
      if (e_push) begin
        ne.wa   = addr[31:2];
        ne.mask = byt ? (4'b0001 << addr[1:0]) : 4'b1111;
        ne.data = byt ? {4{wd[7:0]}} : wd;
        sb.push_back(ne);
      end
    end
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 256; i++) begin
      ram[i]    = 32'h0;
      shadow[i] = 32'h0;
    end
    reset = 1'b1; core_we = 1'b0; core_re = 1'b0; core_byte = 1'b0;
    core_addr = 32'h0; core_wd = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state
    idle();
    chk("rst_count", {29'h0, wb_count}, 32'h0);

    // Word store then drain in the idle cycle
    cyc(1'b1, 1'b0, 1'b0, 32'h10, 32'h11223344, 1'b0);
    idle();
    chk("t1_count", {29'h0, wb_count}, 32'h0);
    chk("t1_ram", ram[4], 32'h11223344);

    // Byte store merges into existing word
    ram[8] = 32'hFFFFFFFF; shadow[8] = 32'hFFFFFFFF;
    cyc(1'b1, 1'b0, 1'b1, 32'h21, 32'h000000AB, 1'b0);
    idle();
    chk("t2_ram", ram[8], 32'hFFFFABFF);
    cyc(1'b0, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0);
    chk("t2_ldr", rd_seen, 32'hFFFFABFF);

    // Fill to full, stall on the fifth, then drain in order
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b0, 32'(4 * i), 32'hA0 + 32'(i), 1'b0);
    chk("t3_full", {29'h0, wb_count}, 32'd4);
    cyc(1'b1, 1'b0, 1'b0, 32'h10, 32'hA4, 1'b0);
    chk("t3_stall", {31'h0, st_seen}, 32'h1);
    cyc(1'b1, 1'b0, 1'b0, 32'h10, 32'hA4, 1'b0);
    chk("t3_accept", {31'h0, st_seen}, 32'h0);
    chk("t3_refull", {29'h0, wb_count}, 32'd4);
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      idle();
      n++;
    end
    chk("t3_drained", 32'(sb.size()), 32'h0);
    chk("t3_ram0", ram[0], 32'hA0);
    chk("t3_ram4", ram[4], 32'hA4);

    // Load hazard on a buffered word
    cyc(1'b1, 1'b0, 1'b0, 32'h40, 32'h55, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 32'h40, 32'h0, 1'b0);
    chk("t4_stall", {31'h0, st_seen}, 32'h1);
    cyc(1'b0, 1'b1, 1'b0, 32'h40, 32'h0, 1'b0);
    chk("t4_nostall", {31'h0, st_seen}, 32'h0);
    chk("t4_rd", rd_seen, 32'h55);

    // Zero-extended byte load, empty buffer
    ram[16] = 32'hDEADBEEF; shadow[16] = 32'hDEADBEEF;
    cyc(1'b0, 1'b1, 1'b1, 32'h43, 32'h0, 1'b0);
    chk("t5_rdb", rd_seen, 32'h000000DE);

    // Reset discards pending stores
    cyc(1'b1, 1'b0, 1'b0, 32'h80, 32'h1111, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 32'h84, 32'h2222, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 32'h88, 32'h3333, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    repeat (3) idle();
    chk("t6_count", {29'h0, wb_count}, 32'h0);
    chk("t6_ram80", ram[32], 32'h0);
    chk("t6_ram84", ram[33], 32'h0);
    chk("t6_ram88", ram[34], 32'h0);

    n = 0;
    for (int i = 0; i < 256; i++) if (ram[i] !== shadow[i]) n++;
    chk("ram_final", 32'(n), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
